fp_f2fx: RTL and testbench
==========================

FP_F2FX -- requirements
Module: fp_f2fx

Interface
REQ-001 SHALL have parameter EXP, default 8, exponent field width.
REQ-002 SHALL have parameter MANT, default 23, stored mantissa width.
REQ-003 SHALL have parameter WIDTH, default 1+EXP+MANT, input float width.
REQ-004 SHALL have parameter OUT_W, default 24, two's-complement result width (2..64).
REQ-005 SHALL have parameter FRAC, default 0, result fractional bits (0..OUT_W-1).
REQ-006 SHALL have parameter ROUND, default 0: 0 = truncate toward zero, 1 = round-nearest-even.
REQ-007 SHALL have parameter SAT, default 1: 1 = saturate on overflow, 0 = wrap to low OUT_W bits.
REQ-008 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port clock_sreset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port dataa, input, WIDTH, float operand {sign, exponent, mantissa}.
REQ-011 SHALL have port data_valid, input, 1, dataa valid.
REQ-012 SHALL have port data_ready, output, 1, block accepts dataa this cycle.
REQ-013 SHALL have port result, output, OUT_W, fixed-point value, FRAC fractional bits.
REQ-014 SHALL have port overflow, output, 1, result out of range; qualified by result_valid.
REQ-015 SHALL have port result_valid, output, 1, result/overflow valid.
REQ-016 SHALL have port result_ready, input, 1, downstream accepts result.

Function
REQ-017 SHALL be a 3-stage pipeline (decode/align, round, range/sign) with latency exactly 3 cycles from accepted input to result_valid when unstalled.
REQ-018 SHALL define advance en = ~result_valid | result_ready; all stages update only when en=1; data_ready = en.
REQ-019 SHALL accept an input only on data_valid & data_ready; one result per accepted input, in order; throughput 1/cycle with result_ready=1.
REQ-020 SHALL hold result, overflow, result_valid stable while result_valid & ~result_ready.
REQ-021 SHALL insert bubbles (valid=0) for cycles with en=1 and no accepted input.
REQ-022 SHALL treat exponent field 0 (zero/denormal) as value 0, overflow=0, regardless of sign.
REQ-023 SHALL treat exponent field all-ones (inf/NaN) as overflow in the direction of sign.
REQ-024 SHALL compute magnitude = {1,mant} shifted by sh = exp - BIAS + FRAC - MANT, BIAS = 2^(EXP-1)-1; left shift if sh>=0, otherwise right shift by -sh keeping guard bit and sticky OR of all lost bits.
REQ-025 SHALL, with ROUND=1, increment magnitude when guard & (sticky | lsb); with ROUND=0, discard guard/sticky.
REQ-026 SHALL flag overflow when the rounded magnitude exceeds 2^(OUT_W-1)-1 (positive) or 2^(OUT_W-1) (negative), including left shifts moving bits beyond OUT_W and a rounding carry crossing the limit.
REQ-027 SHALL, on overflow, output 2^(OUT_W-1)-1 / -2^(OUT_W-1) when SAT=1, or the low OUT_W bits of the two's-complement value when SAT=0.
REQ-028 SHALL negate the magnitude (two's complement) when sign=1; a magnitude rounding to 0 yields result 0.
REQ-029 SHALL size internal shifters so no intermediate truncation occurs for any exponent before range check.

Reset
REQ-030 SHALL, while clock_sreset=1, clear all stage valid bits; the cycle after, result_valid=0, overflow=0, result=0.
REQ-031 SHALL drop all in-flight data on reset mid-stream; data_ready=1 the cycle after reset deasserts.
REQ-032 SHALL ignore data_valid during reset.

Verification (EXP=8, MANT=23, OUT_W=16, FRAC=0, SAT=1 unless stated)
REQ-033 SHALL cover rounding: 0x40600000 (3.5) -> 4 with ROUND=1, 3 with ROUND=0; 0x40200000 (2.5) -> 2 both modes; 0xBFC00000 (-1.5) -> 0xFFFE ROUND=1, 0xFFFF ROUND=0.
REQ-034 SHALL cover range: 0x4788B800 (70000.0) -> 0x7FFF, overflow=1; 0xC7000000 (-32768.0) -> 0x8000, overflow=0; same 70000.0 with SAT=0 -> 0x1170, overflow=1.
REQ-035 SHALL cover specials: 0x80000000 -> 0x0000; 0x00400000 (denormal) -> 0x0000; 0xFF800000 (-inf) -> 0x8000, overflow=1.
REQ-036 SHALL cover FRAC=8: 0x3FA00000 (1.25) -> 0x0140; 0x3B800000 (2^-8) -> 0x0001.
REQ-037 SHALL cover backpressure: 4 back-to-back inputs, result_ready low 5 cycles after first result_valid -> data_ready=0 during stall, results held stable, all 4 delivered in order, none lost/duplicated.
REQ-038 SHALL cover reset mid-stream: clock_sreset for 1 cycle with 2 inputs in flight -> result_valid=0 next cycle, no stale result ever emitted, next input result after exactly 3 cycles.

Source files
------------

// File: rtl/fp_f2fx.sv
// Float to fixed-point converter: 3-stage pipeline (decode/align, round, range/sign)
// with a single valid/ready handshake where every stage advances together.
module fp_f2fx #(
  parameter int EXP   = 8,
  parameter int MANT  = 23,
  parameter int WIDTH = 1 + EXP + MANT,
  parameter int OUT_W = 24,
  parameter int FRAC  = 0,
  parameter int ROUND = 0,
  parameter int SAT   = 1
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic [WIDTH-1:0] dataa,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [OUT_W-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int BIAS = (1 << (EXP - 1)) - 1;
  // Left shifts are only performed when sh < OUT_W, so this holds them losslessly.
  localparam int MW = OUT_W + MANT + 1;
  localparam int EW = 2 * MANT + 3;
  localparam logic signed [31:0] SH_OFF  = 32'(BIAS - FRAC + MANT);
  localparam logic signed [31:0] OUT_W_S = 32'(OUT_W);
  localparam logic [31:0]        RS_MAX  = 32'(MANT + 2);
  localparam logic [MW:0]        LIM     = {{(MW + 1 - OUT_W){1'b0}}, 1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0]   MAX_P   = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]   MIN_N   = {1'b1, {(OUT_W - 1){1'b0}}};

  logic w_en;
  assign w_en       = ~result_valid | result_ready;
  assign data_ready = w_en;

  // ---------------- stage 1: decode / align ----------------
  logic              w_sign;
  logic [EXP-1:0]    w_exp;
  logic [MANT:0]     w_mant1;
  logic signed [31:0] w_sh;
  logic [31:0]       w_rs_amt;
  logic [EW-1:0]     w_rs_ext;
  logic [MW-1:0]     w_mag;
  logic              w_guard;
  logic              w_sticky;
  logic              w_big;
  logic              w_zero;
  logic              w_inf;

  assign w_sign  = dataa[WIDTH-1];
  assign w_exp   = dataa[MANT +: EXP];
  assign w_mant1 = {1'b1, dataa[MANT-1:0]};
  assign w_sh    = $signed({{(32 - EXP){1'b0}}, w_exp}) - SH_OFF;
  assign w_zero  = (w_exp == '0);
  assign w_inf   = (w_exp == '1);

  always_comb begin
    w_mag    = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_big    = 1'b0;
    w_rs_amt = '0;
    w_rs_ext = '0;
    if (!w_sh[31]) begin
      if (w_sh >= OUT_W_S) w_big = 1'b1;
      else w_mag = MW'(w_mant1) << w_sh[6:0];
    end else begin
      // Clamp: beyond MANT+2 every bit lands in the sticky region anyway.
      w_rs_amt = 32'(-w_sh);
      if (w_rs_amt > RS_MAX) w_rs_amt = RS_MAX;
      w_rs_ext = {w_mant1, {(MANT + 2){1'b0}}} >> w_rs_amt;
      w_mag    = MW'(w_rs_ext[EW-1:MANT+2]);
      w_guard  = w_rs_ext[MANT+1];
      w_sticky = |w_rs_ext[MANT:0];
    end
  end

  logic          r_v1, r_s1, r_z1, r_inf1, r_big1, r_g1, r_st1;
  logic [MW-1:0] r_mag1;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_v1   <= 1'b0;
      r_s1   <= 1'b0;
      r_z1   <= 1'b0;
      r_inf1 <= 1'b0;
      r_big1 <= 1'b0;
      r_g1   <= 1'b0;
      r_st1  <= 1'b0;
      r_mag1 <= '0;
    end else if (w_en) begin
      r_v1   <= data_valid;
      r_s1   <= w_sign;
      r_z1   <= w_zero;
      r_inf1 <= w_inf;
      r_big1 <= w_big & ~w_inf & ~w_zero;
      r_g1   <= w_guard;
      r_st1  <= w_sticky;
      r_mag1 <= w_mag;
    end
  end

  // ---------------- stage 2: round ----------------
  logic w_inc;
  assign w_inc = (ROUND != 0) & r_g1 & (r_st1 | r_mag1[0]);

  logic        r_v2, r_s2, r_z2, r_inf2, r_big2;
  logic [MW:0] r_mag2;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_v2   <= 1'b0;
      r_s2   <= 1'b0;
      r_z2   <= 1'b0;
      r_inf2 <= 1'b0;
      r_big2 <= 1'b0;
      r_mag2 <= '0;
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_s2   <= r_s1;
      r_z2   <= r_z1;
      r_inf2 <= r_inf1;
      r_big2 <= r_big1;
      r_mag2 <= {1'b0, r_mag1} + {{MW{1'b0}}, w_inc};
    end
  end

  // ---------------- stage 3: range / sign ----------------
  logic             w_rng, w_ovf;
  logic [MW:0]      w_neg;
  logic [OUT_W-1:0] w_res;

  assign w_rng = r_s2 ? (r_mag2 > LIM) : (r_mag2 >= LIM);
  assign w_ovf = ~r_z2 & (r_inf2 | r_big2 | w_rng);
  assign w_neg = ~r_mag2 + (MW + 1)'(1);

  // Inf/NaN always saturate; huge finite values wrap to zero since their low bits are zero.
  always_comb begin
    w_res = '0;
    if (r_z2)                            w_res = '0;
    else if (r_inf2 || (SAT != 0 && w_ovf)) w_res = r_s2 ? MIN_N : MAX_P;
    else if (r_big2)                     w_res = '0;
    else                                 w_res = r_s2 ? w_neg[OUT_W-1:0] : r_mag2[OUT_W-1:0];
  end

  logic             r_v3, r_ovf3;
  logic [OUT_W-1:0] r_res3;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_v3   <= 1'b0;
      r_ovf3 <= 1'b0;
      r_res3 <= '0;
    end else if (w_en) begin
      r_v3   <= r_v2;
      r_ovf3 <= w_ovf;
      r_res3 <= w_res;
    end
  end

  assign result_valid = r_v3;
  assign overflow     = r_ovf3;
  assign result       = r_res3;

endmodule

// File: tb/tb_fp_f2fx.sv
// Bench for fp_f2fx: four parameterisations driven in lockstep, checked against a
// real-arithmetic model through a scoreboard, plus literal pins on the model itself.
module tb_fp_f2fx;
  localparam int OW = 16;
  localparam int NI = 4;
  localparam int CF_FRAC [NI] = '{0, 0, 0, 8};
  localparam int CF_RND  [NI] = '{1, 0, 0, 1};
  localparam int CF_SAT  [NI] = '{1, 1, 0, 1};

  logic          clock = 1'b0;
  logic          clock_sreset;
  logic [31:0]   dataa;
  logic          data_valid;
  logic          result_ready;
  logic [NI-1:0] dr, rv, ov;
  logic [OW-1:0] res [NI];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fp_f2fx #(.OUT_W(OW), .FRAC(0), .ROUND(1), .SAT(1)) u_a (
    .clock(clock), .clock_sreset(clock_sreset), .dataa(dataa), .data_valid(data_valid),
    .data_ready(dr[0]), .result(res[0]), .overflow(ov[0]), .result_valid(rv[0]),
    .result_ready(result_ready));
  fp_f2fx #(.OUT_W(OW), .FRAC(0), .ROUND(0), .SAT(1)) u_b (
    .clock(clock), .clock_sreset(clock_sreset), .dataa(dataa), .data_valid(data_valid),
    .data_ready(dr[1]), .result(res[1]), .overflow(ov[1]), .result_valid(rv[1]),
    .result_ready(result_ready));
  fp_f2fx #(.OUT_W(OW), .FRAC(0), .ROUND(0), .SAT(0)) u_c (
    .clock(clock), .clock_sreset(clock_sreset), .dataa(dataa), .data_valid(data_valid),
    .data_ready(dr[2]), .result(res[2]), .overflow(ov[2]), .result_valid(rv[2]),
    .result_ready(result_ready));
  fp_f2fx #(.OUT_W(OW), .FRAC(8), .ROUND(1), .SAT(1)) u_d (
    .clock(clock), .clock_sreset(clock_sreset), .dataa(dataa), .data_valid(data_valid),
    .data_ready(dr[3]), .result(res[3]), .overflow(ov[3]), .result_valid(rv[3]),
    .result_ready(result_ready));

  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  // Exact value of the float as a real, scaled, rounded and range-checked. Returns {ovf, result}.
  function automatic logic [16:0] model(input logic [31:0] x, input int frac, input int rnd,
                                        input int sat);
    int e;
    real v, fl, rem;
    longint q;
    logic s, o;
    logic [15:0] r;
    s = x[31];
    e = int'(x[30:23]);
    if (e == 0) return 17'd0;
    if (e == 255) return {1'b1, s ? 16'h8000 : 16'h7FFF};
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    for (int k = 0; k < e - 127 + frac; k++) v = v * 2.0;
    for (int k = 0; k < 127 - e - frac; k++) v = v / 2.0;
    if (v >= 1099511627776.0) return {1'b1, (sat != 0) ? (s ? 16'h8000 : 16'h7FFF) : 16'h0000};
    fl  = $floor(v);
    rem = v - fl;
    q   = longint'(fl);
    if (rnd != 0 && (rem > 0.5 || (rem == 0.5 && q[0]))) q++;
    o = s ? (q > 64'sd32768) : (q > 64'sd32767);
    if (o && sat != 0) r = s ? 16'h8000 : 16'h7FFF;
    else               r = s ? 16'(-q) : 16'(q);
    return {o, r};
  endfunction

  typedef struct packed {
    logic [NI-1:0][16:0] e;
    logic [31:0]         x;
    int                  acc;
    int                  stl;
  } exp_t;
  exp_t sb [$];

  logic          hold_armed = 1'b0;
  logic [OW-1:0] hold_res [NI];
  logic [NI-1:0] hold_ov;

  // Single compare process: push on accept, compare on consume, check holds while stalled.
  always @(negedge clock) begin
    exp_t it;
    if (clock_sreset) begin
      sb.delete();
      hold_armed = 1'b0;
    end else begin
      if (data_valid && dr[0]) begin
        for (int i = 0; i < NI; i++) it.e[i] = model(dataa, CF_FRAC[i], CF_RND[i], CF_SAT[i]);
        it.x   = dataa;
        it.acc = cyc;
        it.stl = stall_cnt;
        sb.push_back(it);
      end
      if (hold_armed) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("hold_res_u%0d", i), res[i], hold_res[i]);
          chk($sformatf("hold_ovf_u%0d", i), ov[i], hold_ov[i]);
        end
        hold_armed = 1'b0;
      end
      if (rv != '0 && rv != '1) chk("valid_lockstep", rv, '1);
      if (rv[0]) begin
        if (sb.size() == 0) begin
          chk("spurious_result", 1, 0);
        end else if (result_ready) begin
          it = sb.pop_front();
          for (int i = 0; i < NI; i++) begin
            chk($sformatf("res_u%0d", i), res[i], it.e[i][15:0]);
            chk($sformatf("ovf_u%0d", i), ov[i], it.e[i][16]);
          end
          if (stall_cnt == it.stl) chk("latency", cyc - it.acc, 3);
          $display("[TB] out x=%h res=%h/%h/%h/%h ovf=%b lat=%0d", it.x, res[0], res[1],
                   res[2], res[3], ov, cyc - it.acc);
        end else begin
          chk("ready_low_in_stall", dr, 0);
          for (int i = 0; i < NI; i++) hold_res[i] = res[i];
          hold_ov    = ov;
          hold_armed = 1'b1;
          stall_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] x);
    int n = 0;
    dataa      = x;
    data_valid = 1'b1;
    @(negedge clock);
    while (!dr[0] && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!dr[0]) chk("send_timeout", 0, 1);
    @(posedge clock);
    #1 data_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_valid_u%0d", tag, i), rv[i], 0);
      chk($sformatf("%s_ovf_u%0d", tag, i), ov[i], 0);
      chk($sformatf("%s_res_u%0d", tag, i), res[i], 0);
      chk($sformatf("%s_ready_u%0d", tag, i), dr[i], 1);
    end
  endtask

  typedef struct { logic [31:0] x; int f; int r; int s; logic [16:0] e; } pin_t;
  pin_t pins [14] = '{
    '{32'h40600000, 0, 1, 1, 17'h00004}, '{32'h40600000, 0, 0, 1, 17'h00003},
    '{32'h40200000, 0, 1, 1, 17'h00002}, '{32'h40200000, 0, 0, 1, 17'h00002},
    '{32'hBFC00000, 0, 1, 1, 17'h0FFFE}, '{32'hBFC00000, 0, 0, 1, 17'h0FFFF},
    '{32'h4788B800, 0, 1, 1, 17'h17FFF}, '{32'hC7000000, 0, 1, 1, 17'h08000},
    '{32'h4788B800, 0, 0, 0, 17'h11170}, '{32'h80000000, 0, 1, 1, 17'h00000},
    '{32'h00400000, 0, 1, 1, 17'h00000}, '{32'hFF800000, 0, 1, 1, 17'h18000},
    '{32'h3FA00000, 8, 1, 1, 17'h00140}, '{32'h3B800000, 8, 1, 1, 17'h00001}};

  logic [31:0] vec [20] = '{
    32'h40600000, 32'h40200000, 32'hBFC00000, 32'h4788B800, 32'hC7000000,
    32'h80000000, 32'h00400000, 32'hFF800000, 32'h3FA00000, 32'h3B800000,
    32'h3F000000, 32'h3FC00000, 32'h46FFFE00, 32'h47000000, 32'hC7000080,
    32'h477FFF80, 32'h5F000000, 32'h7FC00000, 32'h3EFFFFFF, 32'hBF000000};

  logic [31:0] bp_vec [4] = '{32'h3F800000, 32'hC0400000, 32'h42F60000, 32'h40600000};

  initial begin
    clock_sreset = 1'b1;
    data_valid   = 1'b1;
    dataa        = 32'h3F800000;
    result_ready = 1'b1;
    for (int i = 0; i < 14; i++)
      chk($sformatf("model_pin%0d", i), model(pins[i].x, pins[i].f, pins[i].r, pins[i].s),
          pins[i].e);

    repeat (3) @(posedge clock);
    #1 clock_sreset = 1'b0;
    data_valid = 1'b0;
    @(negedge clock);
    chk_idle("reset");

    for (int i = 0; i < 20; i++) begin
      send(vec[i]);
      if (i % 3 == 2) begin
        @(posedge clock);
        #1;
      end
    end
    drain();

    fork
      begin
        for (int i = 0; i < 4; i++) send(bp_vec[i]);
      end
      begin
        int n = 0;
        @(posedge clock);
        #1;
        while (!rv[0] && n < 20) begin
          @(posedge clock);
          #1;
          n++;
        end
        if (!rv[0]) chk("bp_wait_timeout", 0, 1);
        result_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 result_ready = 1'b1;
      end
    join
    drain();

    send(32'h40600000);
    send(32'h4788B800);
    clock_sreset = 1'b1;
    @(posedge clock);
    #1 clock_sreset = 1'b0;
    @(negedge clock);
    chk_idle("midreset");
    send(32'hBFC00000);
    drain();
    repeat (4) @(negedge clock);
    chk("final_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
